// File: rtl/jtag_master_pkg.sv
// Shared encodings for the JTAG scan master: command opcodes, FSM states, reset sequence length.
package jtag_master_pkg;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  localparam int RESET_TMS_CYCLES = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TLR_SEQ,
    ST_SEL_DR,
    ST_SEL_IR,
    ST_CAPTURE,
    ST_SHIFT,
    ST_EXIT1,
    ST_UPDATE,
    ST_RUN,
    ST_DONE
  } jtag_state_e;

endpackage

// File: rtl/jtag_scan_master_tck_gen.sv
// TCK divider: low phase then high phase, each HALF_PERIOD clk; strobes mark the clk before each edge.
module jtag_tck_gen #(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          phase_end;

  assign phase_end = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tck <= 1'b0;
      cnt <= CW'(HALF_PERIOD - 1);
    end else if (en) begin
      if (phase_end) begin
        tck <= ~tck;
        cnt <= CW'(HALF_PERIOD - 1);
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign rise = en && !clr && phase_end && !tck;
  assign fall = en && !clr && phase_end && tck;

endmodule

// File: rtl/jtag_scan_master.sv
// Host-side JTAG sequencer: RESET / IR scan / DR scan / idle clocks from Run-Test/Idle, LSB first.
// Optional trst_n output enabled by defining JTAG_SCAN_MASTER_TRST_EN.
//
// state      | meaning
// IDLE       | waiting for a command, tck held low
// TLR_SEQ    | TMS 1,1,1,1,1,0 to force Test-Logic-Reset then Run-Test/Idle
// SEL_DR     | TMS=1, RTI -> Select-DR
// SEL_IR     | TMS=1, Select-DR -> Select-IR (IR scans only)
// CAPTURE    | two TMS=0 cycles: -> Capture, Capture -> Shift
// SHIFT      | one cycle per bit, TMS=1 on the last
// EXIT1      | TMS=1, Exit1 -> Update
// UPDATE     | TMS=0, Update -> Run-Test/Idle
// RUN        | idle TCK cycles with TMS=0; also the zero-length path
// DONE       | one-clk response, ready for the next command
module jtag_scan_master
  import jtag_master_pkg::*;
#(
  parameter int MAX_LEN     = 8,
  parameter int HALF_PERIOD = 1,
  parameter int LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
`ifdef JTAG_SCAN_MASTER_TRST_EN
  output logic               trst_n,
`endif
  input  logic               tdo
);

  localparam int CNT_W = (LEN_W < 3) ? 3 : LEN_W;

  jtag_state_e        state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               is_ir, is_ir_nxt;
  logic [LEN_W-1:0]   len_r, len_nxt, len_c;
  logic [MAX_LEN-1:0] data_r, data_nxt, rsp_r, rsp_nxt;
  logic               tms_r, tms_nxt, tdi_r, tdi_nxt;
  logic               tck_en, rise, fall;

  assign len_c = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;

  // RUN with a zero count must not toggle tck
  assign tck_en = (state inside {ST_TLR_SEQ, ST_SEL_DR, ST_SEL_IR, ST_CAPTURE,
                                 ST_SHIFT, ST_EXIT1, ST_UPDATE})
                  || (state == ST_RUN && cnt != '0);

  jtag_tck_gen #(.HALF_PERIOD(HALF_PERIOD)) u_tck_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (tck_en),
    .clr  (!tck_en),
    .tck  (tck),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      is_ir  <= 1'b0;
      len_r  <= '0;
      data_r <= '0;
      rsp_r  <= '0;
      tms_r  <= 1'b1;
      tdi_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      is_ir  <= is_ir_nxt;
      len_r  <= len_nxt;
      data_r <= data_nxt;
      rsp_r  <= rsp_nxt;
      tms_r  <= tms_nxt;
      tdi_r  <= tdi_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    is_ir_nxt = is_ir;
    len_nxt   = len_r;
    data_nxt  = data_r;
    rsp_nxt   = rsp_r;
    tms_nxt   = tms_r;
    tdi_nxt   = tdi_r;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (state == ST_DONE) state_nxt = ST_IDLE;
        if (cmd_valid) begin
          len_nxt   = len_c;
          data_nxt  = cmd_data;
          rsp_nxt   = '0;
          tdi_nxt   = 1'b0;
          is_ir_nxt = (cmd_op == OP_IR);
          if (cmd_op == OP_RESET) begin
            state_nxt = ST_TLR_SEQ;
            cnt_nxt   = CNT_W'(RESET_TMS_CYCLES - 1);
            tms_nxt   = 1'b1;
          end else if (len_c == '0) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end else if (cmd_op == OP_IDLE) begin
            state_nxt = ST_RUN;
            cnt_nxt   = CNT_W'(len_c);
            tms_nxt   = 1'b0;
          end else begin
            state_nxt = ST_SEL_DR;
            tms_nxt   = 1'b1;
          end
        end
      end
      ST_TLR_SEQ: if (fall) begin
        if (cnt == '0) state_nxt = ST_DONE;
        else begin
          cnt_nxt = cnt - CNT_W'(1);
          tms_nxt = (cnt != CNT_W'(1));
        end
      end
      ST_SEL_DR: if (fall) begin
        if (is_ir) state_nxt = ST_SEL_IR;
        else begin
          state_nxt = ST_CAPTURE;
          cnt_nxt   = CNT_W'(1);
          tms_nxt   = 1'b0;
        end
      end
      ST_SEL_IR: if (fall) begin
        state_nxt = ST_CAPTURE;
        cnt_nxt   = CNT_W'(1);
        tms_nxt   = 1'b0;
      end
      ST_CAPTURE: if (fall) begin
        if (cnt != '0) cnt_nxt = '0;
        else begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = CNT_W'(len_r);
          tms_nxt   = (len_r == LEN_W'(1));
          tdi_nxt   = data_r[0];
          data_nxt  = data_r >> 1;
        end
      end
      ST_SHIFT: begin
        // captured bits enter at the top and are right-aligned after the last one
        if (rise) rsp_nxt = {tdo, rsp_r[MAX_LEN-1:1]};
        if (fall) begin
          if (cnt == CNT_W'(1)) begin
            state_nxt = ST_EXIT1;
            tms_nxt   = 1'b1;
            tdi_nxt   = 1'b0;
            rsp_nxt   = rsp_r >> (LEN_W'(MAX_LEN) - len_r);
          end else begin
            cnt_nxt  = cnt - CNT_W'(1);
            tms_nxt  = (cnt == CNT_W'(2));
            tdi_nxt  = data_r[0];
            data_nxt = data_r >> 1;
          end
        end
      end
      ST_EXIT1: if (fall) begin
        state_nxt = ST_UPDATE;
        tms_nxt   = 1'b0;
      end
      ST_UPDATE: if (fall) state_nxt = ST_DONE;
      ST_RUN: begin
        if (cnt == '0) state_nxt = ST_DONE;
        else if (fall) begin
          if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
          else cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE) || (state == ST_DONE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state == ST_DONE);
  assign rsp_data  = rsp_r;
  assign tms       = tms_r;
  assign tdi       = tdi_r;

`ifdef JTAG_SCAN_MASTER_TRST_EN
  assign trst_n = !(state == ST_TLR_SEQ && cnt >= CNT_W'(RESET_TMS_CYCLES - 2));
`endif

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master against a behavioural TAP (IDCODE 8'hAA, IR 01=IDCODE, 11=BYPASS).
module tb_jtag_scan_master;
  import jtag_master_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, rsp_valid, busy, tck, tms, tdi;
  logic [1:0] cmd_op;
  logic [3:0] cmd_len;
  logic [7:0] cmd_data, rsp_data;
  logic       tdo = 1'b0;
`ifdef JTAG_SCAN_MASTER_TRST_EN
  logic       trst_n;
`endif

  always #5 clk = ~clk;

  jtag_scan_master #(.MAX_LEN(8), .HALF_PERIOD(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi),
`ifdef JTAG_SCAN_MASTER_TRST_EN
    .trst_n(trst_n),
`endif
    .tdo(tdo)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // behavioural TAP
  localparam logic [3:0] T_TLR = 4'd0,  T_RTI = 4'd1,  T_SDS = 4'd2,  T_CDR = 4'd3,
                         T_SDR = 4'd4,  T_E1D = 4'd5,  T_PDR = 4'd6,  T_E2D = 4'd7,
                         T_UDR = 4'd8,  T_SIS = 4'd9,  T_CIR = 4'd10, T_SIR = 4'd11,
                         T_E1I = 4'd12, T_PIR = 4'd13, T_E2I = 4'd14, T_UIR = 4'd15;

  logic [3:0]  tap_st = T_SDR;
  logic [1:0]  tap_ir = 2'b01;
  logic [1:0]  ir_sr  = 2'b00;
  logic [7:0]  dr_sr  = 8'h00;
  logic        byp    = 1'b0;
  int          n_rise = 0;
  logic [31:0] tms_log;
  int          tms_n;
  logic [31:0] tdi_log;
  int          tdi_n;
  logic [3:0]  st_log[$];

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      T_TLR: return m ? T_TLR : T_RTI;
      T_RTI: return m ? T_SDS : T_RTI;
      T_SDS: return m ? T_SIS : T_CDR;
      T_CDR: return m ? T_E1D : T_SDR;
      T_SDR: return m ? T_E1D : T_SDR;
      T_E1D: return m ? T_UDR : T_PDR;
      T_PDR: return m ? T_E2D : T_PDR;
      T_E2D: return m ? T_UDR : T_SDR;
      T_UDR: return m ? T_SDS : T_RTI;
      T_SIS: return m ? T_TLR : T_CIR;
      T_CIR: return m ? T_E1I : T_SIR;
      T_SIR: return m ? T_E1I : T_SIR;
      T_E1I: return m ? T_UIR : T_PIR;
      T_PIR: return m ? T_E2I : T_PIR;
      T_E2I: return m ? T_UIR : T_SIR;
      default: return m ? T_SDS : T_RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    n_rise++;
    if (tms_n < 32) tms_log[tms_n] = tms;
    tms_n++;
    case (tap_st)
      T_CDR: if (tap_ir == 2'b01) dr_sr = 8'hAA; else byp = 1'b0;
      T_SDR: begin
        if (tdi_n < 32) tdi_log[tdi_n] = tdi;
        tdi_n++;
        if (tap_ir == 2'b01) dr_sr = {tdi, dr_sr[7:1]}; else byp = tdi;
      end
      T_CIR: ir_sr = 2'b01;
      T_SIR: begin
        if (tdi_n < 32) tdi_log[tdi_n] = tdi;
        tdi_n++;
        ir_sr = {tdi, ir_sr[1]};
      end
      T_UIR: tap_ir = ir_sr;
      T_TLR: tap_ir = 2'b01;
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms);
    st_log.push_back(tap_st);
  end

  always @(negedge tck)
    tdo = (tap_st == T_SDR) ? ((tap_ir == 2'b01) ? dr_sr[0] : byp)
        : (tap_st == T_SIR) ? ir_sr[0] : 1'b0;

  // scoreboard
  logic [7:0] exp_q[$];
  int         n_rsp = 0;

  always @(negedge clk) begin
    if (rsp_valid) begin
      n_rsp++;
      check_val("ready_with_rsp", {31'd0, cmd_ready}, 32'd1);
      if (exp_q.size() == 0) check_val("rsp_unexpected", 32'd1, 32'd0);
      else check_val("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
    end
  end

  function automatic void exp_tms(input logic [1:0] op, input int len,
                                  output logic [31:0] v, output int n);
    int lc;
    lc = (len > 8) ? 8 : len;
    v = '0;
    n = 0;
    if (op == OP_RESET) begin
      v = 32'b011111;
      n = 6;
    end else if (op == OP_IDLE) begin
      n = lc;
    end else if (lc != 0) begin
      v[n] = 1'b1; n++;
      if (op == OP_IR) begin v[n] = 1'b1; n++; end
      n += 2;
      n += lc;
      v[n-1] = 1'b1;
      v[n] = 1'b1; n++;
      n++;
    end
  endfunction

  task automatic clear_logs();
    tms_n = 0; tms_log = '0; tdi_n = 0; tdi_log = '0; st_log.delete();
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input int len,
                         input logic [7:0] data, input logic [7:0] exp_rsp, input int exp_busy);
    int lc, guard, nb, r0, v_n;
    logic [31:0] v, mask;
    lc = (len > 8) ? 8 : len;
    @(negedge clk);
    clear_logs();
    r0 = n_rsp;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = 4'(len); cmd_data = data;
    exp_q.push_back(exp_rsp);
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    nb = 0; guard = 0;
    while (!rsp_valid && guard < 300) begin
      if (busy) nb++;
      @(negedge clk);
      guard++;
    end
    check_val({tag, "_timeout"}, (guard >= 300) ? 32'd1 : 32'd0, 32'd0);
    check_val({tag, "_busy_clks"}, nb, exp_busy);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val({tag, "_rsp_count"}, n_rsp - r0, 32'd1);
    exp_tms(op, len, v, v_n);
    check_val({tag, "_tck_count"}, tms_n, v_n);
    check_val({tag, "_tms_seq"}, tms_log, v);
    if ((op == OP_IR || op == OP_DR) && lc != 0) begin
      mask = (32'd1 << lc) - 32'd1;
      check_val({tag, "_tdi_seq"}, tdi_log, {24'd0, data} & mask);
    end
    check_val({tag, "_tap_rti"}, {28'd0, tap_st}, {28'd0, T_RTI});
  endtask

  initial begin
    int guard, r0, r1;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 4'd0; cmd_data = 8'd0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", {26'd0, tck, tms, tdi, cmd_ready, busy, rsp_valid}, 32'b010100);
    check_val("reset_rsp_data", {24'd0, rsp_data}, 32'd0);
    rst = 1'b0;

    // TAP reset from an arbitrary state
    run_cmd("reset", OP_RESET, 0, 8'h00, 8'h00, 12);
    check_val("tlr_reached", (st_log.size() >= 6) ? {28'd0, st_log[4]} : 32'hF, {28'd0, T_TLR});
    check_val("rti_after_tlr", (st_log.size() >= 6) ? {28'd0, st_log[5]} : 32'hF, {28'd0, T_RTI});

    // IR scans capture 2'b01; IDCODE read; clamp of an oversize length
    run_cmd("ir_idcode", OP_IR, 2, 8'h01, 8'h01, 16);
    check_val("ir_idcode_reg", {30'd0, tap_ir}, 32'd1);
    run_cmd("dr_idcode", OP_DR, 8, 8'h00, 8'hAA, 26);
    run_cmd("dr_clamp", OP_DR, 15, 8'h00, 8'hAA, 26);

    // bypass delays data by one bit; upper data bits must not leak
    run_cmd("ir_bypass", OP_IR, 2, 8'h03, 8'h01, 16);
    check_val("ir_bypass_reg", {30'd0, tap_ir}, 32'd3);
    run_cmd("dr_bypass", OP_DR, 4, 8'hFB, 8'h06, 18);
    run_cmd("dr_len0", OP_DR, 0, 8'hFF, 8'h00, 1);

    // back-to-back with cmd_valid held: IDLE 3 then DR len 0
    @(negedge clk);
    clear_logs();
    r0 = n_rise;
    cmd_valid = 1'b1; cmd_op = OP_IDLE; cmd_len = 4'd3; cmd_data = 8'hFF;
    exp_q.push_back(8'h00);
    @(negedge clk);
    check_val("b2b_ready_low", {31'd0, cmd_ready}, 32'd0);
    cmd_op = OP_DR; cmd_len = 4'd0;
    exp_q.push_back(8'h00);
    guard = 0;
    while (!rsp_valid && guard < 100) begin @(negedge clk); guard++; end
    check_val("b2b_idle_timeout", (guard >= 100) ? 32'd1 : 32'd0, 32'd0);
    check_val("b2b_idle_rises", n_rise - r0, 32'd3);
    check_val("b2b_idle_tms", {tms_log[31:3], 3'b000} | {29'd0, tms_log[2:0]}, 32'd0);
    r1 = n_rise;
    @(negedge clk);
    check_val("b2b_dr0_busy", {30'd0, rsp_valid, busy}, 32'b01);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_val("b2b_dr0_rsp", {31'd0, rsp_valid}, 32'd1);
    check_val("b2b_dr0_no_tck", n_rise - r1, 32'd0);

    // reset during DR shift bit 3
    @(negedge clk);
    clear_logs();
    cmd_valid = 1'b1; cmd_op = OP_DR; cmd_len = 4'd8; cmd_data = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (tdi_n < 3 && guard < 200) begin @(negedge clk); guard++; end
    check_val("abort_reach_shift", (guard >= 200) ? 32'd1 : 32'd0, 32'd0);
    @(negedge clk);
    r0 = n_rsp;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_outputs", {27'd0, tck, tms, tdi, busy, rsp_valid}, 32'b01000);
    repeat (10) @(negedge clk);
    #1;
    check_val("abort_no_rsp", n_rsp - r0, 32'd0);
    run_cmd("reset_after_abort", OP_RESET, 0, 8'h00, 8'h00, 12);

    check_val("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Host-side JTAG sequencer that drives TCK/TMS/TDI into the team's 4-bit-state TAP block and collects TDO.
- Accepts one command at a time from a local controller: TAP reset, IR scan, DR scan or idle clocks.
- Walks the IEEE 1149.1 state machine from Run-Test/Idle and back, shifting LSB first.
- Returns captured TDO bits in a response pulse.

Parameters:
- MAX_LEN, 8: maximum scan length in bits; also the width of the data buses.
- HALF_PERIOD, 1: clk cycles per TCK phase, 1 or more; the TCK period is 2*HALF_PERIOD clk cycles.
- LEN_W, $clog2(MAX_LEN+1): width of cmd_len.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- cmd_valid, input, 1: command offered.
- cmd_ready, output, 1: block idle and able to accept a command.
- cmd_op, input, 2: 0=RESET, 1=IR_SCAN, 2=DR_SCAN, 3=IDLE.
- cmd_len, input, LEN_W: scan bit count, or TCK count for IDLE.
- cmd_data, input, MAX_LEN: TDI bits; bit0 is shifted first.
- rsp_valid, output, 1: one-cycle completion pulse.
- rsp_data, output, MAX_LEN: captured TDO bits; bit0 is captured first; bits at index cmd_len and above are 0.
- busy, output, 1: command in progress; equals ~cmd_ready.
- tck, output, 1: JTAG clock.
- tms, output, 1: JTAG mode select.
- tdi, output, 1: JTAG data to the TAP.
- tdo, input, 1: JTAG data from the TAP; synchronised externally.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0. Internal FSM goes to IDLE and the divider clears.
- Handshake: a command is accepted on a clk edge with cmd_valid && cmd_ready. op, len and data are registered, and cmd_ready drops the next cycle.
- rsp_valid has no backpressure and lasts exactly one clk.
- cmd_ready rises in the same cycle as rsp_valid, so a held cmd_valid is accepted on the following edge.
- TCK generation: tck is held low while idle.
  - Each TCK cycle is a low phase followed by a high phase, each HALF_PERIOD clk long.
  - tms/tdi update only on the clk where tck goes low (fall strobe).
  - tdo is sampled on the clk where tck goes high (rise strobe).
- FSM states: IDLE, TLR_SEQ, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RUN, DONE.
- One TCK cycle per listed TMS value. The TAP is assumed to be in Run-Test/Idle at the start of every non-RESET op; that is the host's responsibility.
- RESET: TMS 1,1,1,1,1,0 (6 TCK). tdi=0. rsp_data=0.
- DR_SCAN, L bits: TMS 1 (SEL_DR), 0 (CAPTURE), 0 (SHIFT entry), then L shift cycles, then 1 (EXIT1->UPDATE), 0 (->RTI). Total L+5 TCK.
  - Shift cycles: TMS=0 for the first L-1 bits and TMS=1 on bit L-1; TDI=data[i].
  - tdo sampled on each shift rising edge is stored at rsp_data[i].
- IR_SCAN: identical to DR_SCAN with an extra leading TMS=1 (SEL_IR). Total L+6 TCK.
- IDLE: len TCK cycles with tms=0, tdi=0. rsp_data=0.
- tdi returns to 0 and tms is held at its last value outside SHIFT.
- Boundaries:
  - cmd_len=0 on any scan or IDLE: no TCK activity; rsp_valid fires 1 clk after acceptance with rsp_data=0.
  - cmd_len>MAX_LEN is clamped to MAX_LEN.
  - RESET ignores len and data.
- Completion: DONE is entered on the clk where the final TCK high phase ends (tck returns low). rsp_valid pulses there.
- rst mid-command: the command is abandoned with no rsp_valid. Outputs take their reset values on the next edge. The TAP state is then undefined, and the host must issue RESET.

Optional Feature:
- JTAG_SCAN_MASTER_TRST_EN: adds output port trst_n (1 bit).
  - trst_n is 1 at reset and when idle.
  - During a RESET op it is driven 0 for the first 2 TCK cycles of the sequence. The TMS sequence is unchanged.
- Without the macro the port is absent and reset relies on TMS only.

Decomposition:
- Package jtag_master_pkg:
  - cmd_op encoding localparams (OP_RESET, OP_IR, OP_DR, OP_IDLE).
  - FSM state encoding.
  - RESET_TMS_CYCLES=6.
- Sub-module jtag_tck_gen: HALF_PERIOD divider with enable and sync clear. Outputs tck, a rise strobe and a fall strobe.

Test Plan (HALF_PERIOD=1, bench connects the team TAP block with IDCODE 8'hAA; 2'b01=IDCODE, 2'b11=BYPASS):
1. RESET op -> tms sequence 1,1,1,1,1,0 over 6 rising tck; TAP debug state=0000 then 0001; rsp_valid 1 clk with rsp_data=0; total 12 clk busy.
2. IR_SCAN len=2, data=2'b01 -> tms 1,1,0,0,0,1,1,0; tdi 1 then 0 in shift; TAP instruction bits read 01 after update; TAP back in Run-Test/Idle.
3. IR_SCAN 01 then DR_SCAN len=8, data=0 -> rsp_data=8'hAA, per the TAP's TDO timing model; rsp_valid exactly once per command.
4. IR_SCAN 11 (bypass) then DR_SCAN len=4, data=4'b1011 -> rsp_data equals data delayed by one bit (4'b0110); bit index L and above = 0.
5. Back-to-back: cmd_valid held with IDLE len=3 then DR len=0 -> 3 TCK with tms=0; cmd_ready low while busy, high with rsp_valid; DR len=0 gives rsp_valid 1 clk after acceptance, no tck edge.
6. rst=1 for 1 clk during DR shift bit 3 -> next clk tck=0, tms=1, tdi=0, busy=0, no rsp_valid; a following RESET op completes normally.
